// File: rtl/rc_settle_eval_mc_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rc_settle_eval_mc_if                                                     |
// | Step handshake, per-channel VREF/VREG/enable and packed channel outputs. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rc_settle_eval_mc_if #(
    parameter int CH    = 4,
    parameter int IN_W  = 9,
    parameter int OUT_W = 7
);
    logic                  step_valid;
    logic                  step_ready;
    logic [CH-1:0]         ch_en;
    logic [CH*IN_W-1:0]    VREF;
    logic [CH*IN_W-1:0]    VREG;
    logic [CH*OUT_W-1:0]   out;
    logic                  busy;
    logic                  done;

    modport master (
        output step_valid, ch_en, VREF, VREG,
        input  step_ready, out, busy, done
    );

    modport slave (
        input  step_valid, ch_en, VREF, VREG,
        output step_ready, out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/rc_settle_eval_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rc_settle_eval_mc                                                        |
// | CH first-order settling channels sharing one restoring divider.          |
// | EVAL_SAT_EN: clamp the updated state instead of wrapping it.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rc_settle_eval_mc #(
    parameter int CH      = 4,
    parameter int IN_W    = 9,
    parameter int ST_W    = 32,
    parameter int OUT_W   = 7,
    parameter int TAU_W   = 24,
    parameter int C_VREF  = -1115,
    parameter int C_VREG  = 1131,
    parameter int C_CONST = 1529,
    parameter int TARGET  = 105,
    parameter int GAIN_W  = 8,
    parameter int GAIN    = 175,
    parameter int DT_SH   = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    rc_settle_eval_mc_if.slave bus
);
    localparam int DV_W  = ST_W + GAIN_W;
    localparam int N_W   = DV_W + 2;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int TR_W  = IN_W + 34;
    localparam int CNT_W = $clog2(DV_W);

    localparam logic [ST_W-1:0]        c_target  = ST_W'(TARGET) << (ST_W - OUT_W);
    localparam logic signed [TR_W-1:0] c_vref    = TR_W'(C_VREF);
    localparam logic signed [TR_W-1:0] c_vreg    = TR_W'(C_VREG);
    localparam logic signed [TR_W-1:0] c_const   = TR_W'(C_CONST);
    localparam logic signed [TR_W-1:0] c_tau_max = TR_W'({TAU_W{1'b1}});
    localparam logic [DV_W-1:0]        c_gain    = DV_W'(GAIN);
    localparam logic [CH_W-1:0]        c_last    = CH_W'(CH - 1);
    localparam logic [CNT_W-1:0]       c_div_end = CNT_W'(DV_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [CH-1:0]       en_q;
    logic [CH*IN_W-1:0]  vref_q;
    logic [CH*IN_W-1:0]  vreg_q;
    logic [ST_W-1:0]     o_q [CH];
    logic [TAU_W-1:0]    tau_q;
    logic [TAU_W-1:0]    rem_q;
    logic [DV_W-1:0]     dvd_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;

    logic [IN_W-1:0]        w_vref_ch;
    logic [IN_W-1:0]        w_vreg_ch;
    logic signed [TR_W-1:0] w_tau_raw;
    logic [TAU_W-1:0]       tau_d;
    logic [ST_W-1:0]        w_o_ch;
    logic [ST_W:0]          w_err;
    logic [ST_W:0]          w_abs_err;
    logic [DV_W-1:0]        dvd_ld_d;
    logic [TAU_W:0]         w_rem_sh;
    logic [TAU_W:0]         w_rem_sub;
    logic                   w_qbit;
    logic [TAU_W-1:0]       rem_d;
    logic [DV_W-1:0]        w_delta;
    logic [N_W-1:0]         w_n;
    logic [ST_W-1:0]        o_d;
    logic                   w_unused;

    assign w_vref_ch = vref_q[ch_q*IN_W +: IN_W];
    assign w_vreg_ch = vreg_q[ch_q*IN_W +: IN_W];
    assign w_tau_raw = c_vref * $signed(TR_W'(w_vref_ch))
                     + c_vreg * $signed(TR_W'(w_vreg_ch)) + c_const;

    always_comb begin
        tau_d = w_tau_raw[TAU_W-1:0];
        if (w_tau_raw <= 0)
            tau_d = TAU_W'(1);
        else if (w_tau_raw > c_tau_max)
            tau_d = '1;
    end

    assign w_o_ch    = o_q[ch_q];
    assign w_err     = {1'b0, c_target} - {1'b0, w_o_ch};
    assign w_abs_err = w_err[ST_W] ? (~w_err + 1'b1) : w_err;
    assign dvd_ld_d  = DV_W'(w_abs_err[ST_W-1:0]) * c_gain;

    // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
    assign w_rem_sh  = {rem_q, dvd_q[DV_W-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, tau_q};
    assign w_qbit    = (w_rem_sh >= {1'b0, tau_q});
    assign rem_d     = w_qbit ? w_rem_sub[TAU_W-1:0] : w_rem_sh[TAU_W-1:0];

    assign w_delta = dvd_q >> DT_SH;
    assign w_n     = neg_q ? (N_W'(w_o_ch) - N_W'(w_delta))
                           : (N_W'(w_o_ch) + N_W'(w_delta));

`ifdef EVAL_SAT_EN
    always_comb begin
        o_d = w_n[ST_W-1:0];
        if (w_n[N_W-1])
            o_d = '0;
        else if (|w_n[N_W-2:ST_W])
            o_d = '1;
    end
    assign w_unused = ^{w_rem_sub[TAU_W], w_abs_err[ST_W]};
`else
    assign o_d      = w_n[ST_W-1:0];
    assign w_unused = ^{w_rem_sub[TAU_W], w_abs_err[ST_W], w_n[N_W-1:ST_W]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            en_q    <= '0;
            vref_q  <= '0;
            vreg_q  <= '0;
            for (int i = 0; i < CH; i++) o_q[i] <= '0;
            tau_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.step_valid && ready_q) begin
                        en_q    <= bus.ch_en;
                        vref_q  <= bus.VREF;
                        vreg_q  <= bus.VREG;
                        ch_q    <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (en_q[ch_q]) begin
                        tau_q   <= tau_d;
                        dvd_q   <= dvd_ld_d;
                        rem_q   <= '0;
                        neg_q   <= w_err[ST_W];
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end else if (ch_q == c_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[DV_W-2:0], w_qbit};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == c_div_end)
                        state_q <= S_UPD;
                end
                S_UPD: begin
                    o_q[ch_q] <= o_d;
                    if (ch_q == c_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_out
        assign bus.out[i*OUT_W +: OUT_W] = o_q[i][ST_W-1 -: OUT_W];
    end

    assign bus.step_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
`default_nettype wire

// File: tb/tb_rc_settle_eval_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rc_settle_eval_mc                                                     |
// | Random steps on a default and a high-gain instance against a model.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rc_settle_eval_mc;
    localparam int CH    = 4;
    localparam int IN_W  = 9;
    localparam int OUT_W = 7;
    localparam int DV_W  = 40;
    localparam int VW    = CH * IN_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          step_valid = 1'b0;
    logic [CH-1:0] ch_en = '0;
    logic [VW-1:0] vref = '0;
    logic [VW-1:0] vreg = '0;

    rc_settle_eval_mc_if #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W)) ifa ();
    rc_settle_eval_mc_if #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W)) ifb ();

    assign ifa.step_valid = step_valid;
    assign ifa.ch_en      = ch_en;
    assign ifa.VREF       = vref;
    assign ifa.VREG       = vreg;
    assign ifb.step_valid = step_valid;
    assign ifb.ch_en      = ch_en;
    assign ifb.VREF       = vref;
    assign ifb.VREG       = vreg;

    rc_settle_eval_mc dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    rc_settle_eval_mc #(.GAIN(255), .DT_SH(7)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    // Instance 0: default gain/shift, instance 1: GAIN=255, DT_SH=7.
    longint mo  [2][CH];
    longint nxt [2][CH];
    longint vis [2][CH];
    bit     exp_ready, exp_busy, exp_done, chk_en;
    int     cur_cyc, last_done;
    int     n_chk = 0;
    int     n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint tau_of(input longint vr, input longint vg);
        longint r;
        r = -1115 * vr + 1131 * vg + 1529;
        if (r <= 0) return 1;
        if (r > 64'hFF_FFFF) return 64'hFF_FFFF;
        return r;
    endfunction

    function automatic longint step_o(input longint o, input longint tau, input int inst);
        longint err, mag, g, d, n;
        int sh;
        g   = (inst == 1) ? 255 : 175;
        sh  = (inst == 1) ? 7 : 8;
        err = (longint'(105) <<< 25) - o;
        mag = (err < 0) ? -err : err;
        d   = ((mag * g) / tau) >>> sh;
        n   = (err < 0) ? o - d : o + d;
`ifdef EVAL_SAT_EN
        if (n < 0) n = 0;
        else if (n > 64'hFFFF_FFFF) n = 64'hFFFF_FFFF;
`else
        n = n & 64'hFFFF_FFFF;
`endif
        return n;
    endfunction

    function automatic logic [6:0] oslice(input longint o);
        return 7'((o >> 25) & 127);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("readyA", ifa.step_ready, exp_ready);
            check("busyA",  ifa.busy,       exp_busy);
            check("doneA",  ifa.done,       exp_done);
            check("readyB", ifb.step_ready, exp_ready);
            check("busyB",  ifb.busy,       exp_busy);
            check("doneB",  ifb.done,       exp_done);
            for (int i = 0; i < CH; i++) begin
                check($sformatf("outA%0d", i), ifa.out[i*OUT_W +: OUT_W], oslice(vis[0][i]));
                check($sformatf("outB%0d", i), ifb.out[i*OUT_W +: OUT_W], oslice(vis[1][i]));
            end
            if (ifa.done) last_done = cur_cyc;
        end
    end

    task automatic set_idle();
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        cur_cyc   = 0;
    endtask

    task automatic zero_model();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < CH; i++) begin
                mo[j][i]  = 0;
                vis[j][i] = 0;
            end
    endtask

    // Entered and left at posedge+#1 of an idle cycle. abort_at>0 resets mid-step.
    task automatic run_step(input logic [CH-1:0] en, input logic [VW-1:0] vr,
                            input logic [VW-1:0] vg, input bit hold, input int abort_at);
        int vis_at[CH];
        int s, k;
        step_valid = 1'b1;
        ch_en = en;
        vref  = vr;
        vreg  = vg;
        set_idle();
        @(posedge clk); #1;
        s = 1;
        for (int i = 0; i < CH; i++) begin
            for (int j = 0; j < 2; j++)
                nxt[j][i] = en[i] ? step_o(mo[j][i],
                                           tau_of(longint'(vr[i*IN_W +: IN_W]), longint'(vg[i*IN_W +: IN_W])), j)
                                  : mo[j][i];
            if (en[i]) begin
                vis_at[i] = s + DV_W + 2;
                s += DV_W + 2;
            end else begin
                vis_at[i] = 0;
                s += 1;
            end
        end
        k = s;
        if (!hold) step_valid = 1'b0;
        ch_en = CH'($urandom);
        vref  = VW'({$urandom, $urandom});
        vreg  = VW'({$urandom, $urandom});
        for (int c = 1; c <= k; c++) begin
            cur_cyc   = c;
            exp_busy  = 1'b1;
            exp_ready = 1'b0;
            exp_done  = (c == k);
            for (int i = 0; i < CH; i++)
                for (int j = 0; j < 2; j++)
                    if (en[i] && c >= vis_at[i]) vis[j][i] = nxt[j][i];
            if (c == abort_at) begin
                chk_en = 1'b0;
                step_valid = 1'b0;
                reset_n = 1'b0;
                #1;
                check("abort_out",   ifa.out, 0);
                check("abort_busy",  ifa.busy, 0);
                check("abort_done",  ifa.done, 0);
                check("abort_ready", ifa.step_ready, 1);
                zero_model();
                set_idle();
                @(posedge clk); #1;
                @(posedge clk); #1;
                reset_n = 1'b1;
                chk_en = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < CH; i++)
            for (int j = 0; j < 2; j++) mo[j][i] = nxt[j][i];
        set_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] v511;
        logic [VW-1:0] vr, vg;
        v511 = {CH{9'd511}};
        chk_en = 1'b0;
        last_done = 0;
        zero_model();
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(posedge clk); #1;
        check("reset_out",   ifa.out, 0);
        check("reset_ready", ifa.step_ready, 1);

        // tau clamps to 1 on ch0 only
        run_step(4'b0001, v511, '0, 1'b0, 0);
        check("clamp1_out0", ifa.out[6:0], 71);
`ifdef EVAL_SAT_EN
        check("sat_out0", ifb.out[6:0], 127);
`else
        check("wrap_out0", ifb.out[6:0], 81);
`endif
        check("clamp_done_cyc", last_done, 46);
        run_step(4'b0001, v511, '0, 1'b0, 0);
        check("clamp2_out0", ifa.out[6:0], 94);

        // reset in the middle of ch0's divide
        run_step(4'b1111, '0, '0, 1'b0, 10);
        @(posedge clk); #1;

        run_step(4'b1111, '0, '0, 1'b0, 0);
        check("nom_out0", ifa.out[6:0], 0);
        check("nom_model_o0", mo[0][0], 1575178);
        check("nom_done_cyc", last_done, 169);

        run_step(4'b1011, v511, '0, 1'b0, 0);
        check("iso_out1", ifa.out[13:7], 71);
        check("iso_out2", ifa.out[20:14], 0);

        // valid held high: back-to-back accepts
        for (int t = 0; t < 3; t++) begin
            vr = VW'({$urandom, $urandom});
            vg = VW'({$urandom, $urandom});
            run_step(CH'($urandom), vr, vg, (t < 2), 0);
        end

        for (int t = 0; t < 16; t++) begin
            vr = VW'({$urandom, $urandom});
            vg = VW'({$urandom, $urandom});
            if (t[0]) vr = vr & {CH{9'h03F}};
            run_step(CH'($urandom), vr, vg, bit'($urandom_range(0, 1)), 0);
        end
        step_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
